stream_switch: RTL and testbench
================================

STREAM_SWITCH -- requirements
Module: stream_switch

Interface
REQ-001 SHALL have parameter NCH, default 4, number of downstream channels (2..16).
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have parameter TMO, default 255, read timeout in clocks (1..65535).
REQ-004 SHALL have parameter AUTO, default 0, selection mode: 0 = host-selected, 1 = round-robin on ready data.
REQ-005 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- sel_req  in  clog2(NCH)  requested channel; AUTO=0 only.
- sel_wr  in  1  one-cycle strobe that loads sel_req.
- rd  in  1  host read strobe.
- wr  in  1  host write strobe.
- rd_o  out  NCH  per-channel read strobes.
- wr_o  out  NCH  per-channel write strobes.
- drdy_i  in  NCH  per-channel data-ready.
- d_i  in  NCH*DW  channel k data at bits [k*DW +: DW].
- drdy  out  1  registered data-ready pulse to host.
- d  out  DW  registered data to host.
- cur_sel  out  clog2(NCH)  active channel.
- busy  out  1  high when state is not IDLE.
- tmo_err  out  1  one-cycle timeout pulse.

Function
REQ-006 SHALL implement FSM states IDLE, WAIT and SWITCH.
REQ-007 In IDLE, rd SHALL drive rd_o[cur_sel] combinationally, with every other rd_o bit low, and SHALL enter WAIT.
REQ-008 In IDLE and WAIT, wr SHALL drive wr_o[cur_sel] combinationally; wr SHALL NOT change state.
REQ-009 In WAIT, rd SHALL be ignored and no rd_o SHALL be asserted.
REQ-010 In WAIT, when drdy_i[cur_sel] is high, the next cycle SHALL have d = d_i[cur_sel] and drdy = 1 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-011 In WAIT, a clog2(TMO+1)-bit counter SHALL increment each cycle; on reaching TMO the FSM SHALL go to IDLE, pulse tmo_err for one cycle and leave d unchanged.
REQ-012 sel_wr in any state SHALL latch sel_req into a pending register with a pending flag; a later sel_wr before it is applied SHALL overwrite it (last wins).
REQ-013 The pending selection SHALL be applied only from IDLE, via SWITCH.
REQ-014 SWITCH SHALL last 1 cycle, block rd_o and wr_o, update cur_sel on exit and clear the pending flag.
REQ-015 A sel_req value of NCH or above SHALL be dropped silently.
REQ-016 If rd and a pending switch coincide in IDLE, rd SHALL win and the switch SHALL wait for the next IDLE.
REQ-017 If sel_wr coincides with the SWITCH exit, the new value SHALL stay pending and SHALL NOT be lost.
REQ-018 AUTO=1: sel_req and sel_wr SHALL be ignored.
REQ-019 AUTO=1: in IDLE with no rd, if any drdy_i bit other than cur_sel is set and drdy_i[cur_sel] = 0, the block SHALL go to SWITCH targeting the first set bit after cur_sel, wrapping modulo NCH.
REQ-020 drdy_i from unselected channels SHALL never reach drdy or d.
REQ-021 Read latency SHALL be 1 clock from the sampled drdy_i[cur_sel] to drdy.

Reset
REQ-022 When reset is high at a clk edge, the block SHALL set: state IDLE, cur_sel 0, pending flag 0, counter 0, d 0, drdy 0, tmo_err 0.
REQ-023 While reset is high, rd_o and wr_o SHALL be 0.
REQ-024 Reset during WAIT or SWITCH SHALL abort the operation with no drdy pulse.

Structure
REQ-025 A shared package stream_switch_pkg SHALL hold the FSM state enum and the MODE_MANUAL=0 and MODE_AUTO=1 constants.
REQ-026 The round-robin next-set-bit search SHALL be a sub-module rr_pick (inputs: request vector and base index; outputs: index and valid), purely combinational and parameterised by NCH.
REQ-027 The implementation SHALL fit in 120-400 lines of RTL.

Verification
REQ-028 Bench SHALL cover: NCH=4, cur_sel=2, rd, then drdy_i[2]=1 with d_i chan2=0xA5 -> rd_o=4'b0100 for one cycle, drdy pulse next cycle, d=0xA5.
REQ-029 Bench SHALL cover: rd on chan 1, sel_wr sel_req=3 during WAIT, drdy_i[1] after 5 cycles -> d from chan 1, then SWITCH, then cur_sel=3.
REQ-030 Bench SHALL cover: TMO=10, rd, drdy_i held 0 -> tmo_err pulse on the 10th WAIT cycle, busy low next cycle, d unchanged.
REQ-031 Bench SHALL cover: AUTO=1, cur_sel=3, drdy_i=4'b0011 -> cur_sel=0 after SWITCH.
REQ-032 Bench SHALL cover: sel_wr sel_req=5 with NCH=4 -> cur_sel unchanged and no SWITCH entered.
REQ-033 Bench SHALL cover: reset asserted in WAIT -> no drdy pulse and all outputs at reset values next cycle.

Source files
------------

// File: rtl/stream_switch_pkg.sv
// Shared FSM state encoding and selection-mode constants for the stream switch.
package stream_switch_pkg;

   localparam int unsigned MODE_MANUAL = 0;
   localparam int unsigned MODE_AUTO   = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_SWITCH = 2'd2
   } state_e;

endpackage

// File: rtl/stream_switch_rr_pick.sv
// Combinational round-robin search: nearest set request strictly after base, wrapping.
module rr_pick #(
   parameter int unsigned NCH = 4
) (
   input  logic [NCH-1:0]         req,
   input  logic [$clog2(NCH)-1:0] base,
   output logic [$clog2(NCH)-1:0] idx,
   output logic                   valid
);

   localparam int unsigned SW = $clog2(NCH);

   int unsigned   pos;
   logic [SW-1:0] p;

   always_comb begin
      idx   = base;
      valid = 1'b0;
      pos   = 0;
      p     = '0;
      // Walk from the farthest offset inward so the nearest hit is written last.
      for (int unsigned off = NCH - 1; off > 0; off--) begin
         pos = (32'(base) + off) % NCH;
         p   = SW'(pos);
         if (req[p]) begin
            idx   = p;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_switch.sv
// Stream switch: steers host read/write strobes to one of NCH channels and returns the
// active channel's data; selection is host-driven or round-robin on ready data.
module stream_switch
   import stream_switch_pkg::*;
#(
   parameter int unsigned NCH  = 4,
   parameter int unsigned DW   = 8,
   parameter int unsigned TMO  = 255,
   parameter int unsigned AUTO = MODE_MANUAL
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [$clog2(NCH)-1:0] sel_req,
   input  logic                   sel_wr,
   input  logic                   rd,
   input  logic                   wr,
   output logic [NCH-1:0]         rd_o,
   output logic [NCH-1:0]         wr_o,
   input  logic [NCH-1:0]         drdy_i,
   input  logic [NCH*DW-1:0]      d_i,
   output logic                   drdy,
   output logic [DW-1:0]          d,
   output logic [$clog2(NCH)-1:0] cur_sel,
   output logic                   busy,
   output logic                   tmo_err
);

   localparam int unsigned SW      = $clog2(NCH);
   localparam int unsigned CW      = $clog2(TMO + 1);
   localparam bit          AUTO_EN = (AUTO == MODE_AUTO);

   state_e        state_q, state_d;
   logic [SW-1:0] cur_q, cur_d;
   logic [SW-1:0] tgt_q, tgt_d;
   logic          pend_q, pend_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] d_q, d_d;
   logic          drdy_q, drdy_d;

   logic [SW-1:0] rr_idx;
   logic          rr_valid;
   logic          sel_drdy;
   logic [DW-1:0] sel_data;
   logic          sel_ok;
   logic          timeout;

   rr_pick #(
      .NCH (NCH)
   ) u_rr_pick (
      .req   (drdy_i),
      .base  (cur_q),
      .idx   (rr_idx),
      .valid (rr_valid)
   );

   assign sel_drdy = drdy_i[cur_q];
   assign sel_data = d_i[32'(cur_q) * DW +: DW];
   assign sel_ok   = !AUTO_EN && sel_wr && (32'(sel_req) < NCH);
   // Counter is 1 in the first WAIT cycle, so it equals TMO in the TMO-th one.
   assign timeout  = (state_q == ST_WAIT) && !sel_drdy && (cnt_q == CW'(TMO));

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      tgt_d   = tgt_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      drdy_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (rd) begin
               state_d = ST_WAIT;
               cnt_d   = CW'(1);
            end else if (!AUTO_EN && pend_q) begin
               state_d = ST_SWITCH;
            end else if (AUTO_EN && rr_valid && !sel_drdy) begin
               state_d = ST_SWITCH;
               tgt_d   = rr_idx;
            end
         end
         ST_WAIT: begin
            if (sel_drdy) begin
               state_d = ST_IDLE;
               d_d     = sel_data;
               drdy_d  = 1'b1;
               cnt_d   = '0;
            end else if (timeout) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_SWITCH: begin
            state_d = ST_IDLE;
            cur_d   = tgt_q;
            pend_d  = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
      // A request landing on the SWITCH exit stays pending for the next IDLE.
      if (sel_ok) begin
         pend_d = 1'b1;
         tgt_d  = sel_req;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cur_q   <= '0;
         tgt_q   <= '0;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
         d_q     <= '0;
         drdy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         drdy_q  <= drdy_d;
      end
   end

   always_comb begin
      rd_o = '0;
      wr_o = '0;
      if (!reset) begin
         if ((state_q == ST_IDLE) && rd) rd_o[cur_q] = 1'b1;
         if ((state_q != ST_SWITCH) && wr) wr_o[cur_q] = 1'b1;
      end
   end

   assign drdy    = drdy_q;
   assign d       = d_q;
   assign cur_sel = cur_q;
   assign busy    = (state_q != ST_IDLE);
   assign tmo_err = timeout && !reset;

endmodule

// File: tb/tb_stream_switch.sv
// Bench for stream_switch: directed scenarios plus randomized traffic on a manual and a
// round-robin instance, checked against a transaction-level reference model.
module tb_stream_switch;

   localparam int NCH = 4;
   localparam int DW  = 8;
   localparam int TMO = 10;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        sel_req;
   logic              sel_wr, rd, wr;
   logic [NCH-1:0]    drdy_i;
   logic [NCH*DW-1:0] d_i;

   logic [NCH-1:0] rd_o_m, wr_o_m, rd_o_a, wr_o_a;
   logic           drdy_m, drdy_a, busy_m, busy_a, tmo_m, tmo_a;
   logic [DW-1:0]  d_m, d_a;
   logic [1:0]     cur_m, cur_a;

   logic [2:0] w_sel_req;
   logic       w_sel_wr;
   logic [4:0] w_rd_o, w_wr_o;
   logic       w_drdy, w_busy, w_tmo;
   logic [7:0] w_d;
   logic [2:0] w_cur;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stream_switch #(.NCH(NCH), .DW(DW), .TMO(TMO), .AUTO(0)) u_man (
      .clk(clk), .reset(reset), .sel_req(sel_req), .sel_wr(sel_wr), .rd(rd), .wr(wr),
      .rd_o(rd_o_m), .wr_o(wr_o_m), .drdy_i(drdy_i), .d_i(d_i), .drdy(drdy_m), .d(d_m),
      .cur_sel(cur_m), .busy(busy_m), .tmo_err(tmo_m)
   );

   stream_switch #(.NCH(NCH), .DW(DW), .TMO(TMO), .AUTO(1)) u_auto (
      .clk(clk), .reset(reset), .sel_req(sel_req), .sel_wr(sel_wr), .rd(rd), .wr(wr),
      .rd_o(rd_o_a), .wr_o(wr_o_a), .drdy_i(drdy_i), .d_i(d_i), .drdy(drdy_a), .d(d_a),
      .cur_sel(cur_a), .busy(busy_a), .tmo_err(tmo_a)
   );

   // Five channels so that out-of-range selections are representable on sel_req.
   stream_switch #(.NCH(5), .DW(8), .TMO(TMO), .AUTO(0)) u_wide (
      .clk(clk), .reset(reset), .sel_req(w_sel_req), .sel_wr(w_sel_wr), .rd(1'b0),
      .wr(1'b0), .rd_o(w_rd_o), .wr_o(w_wr_o), .drdy_i(5'd0), .d_i(40'd0), .drdy(w_drdy),
      .d(w_d), .cur_sel(w_cur), .busy(w_busy), .tmo_err(w_tmo)
   );

   // Reference model, index 0 = host-selected, 1 = round-robin.
   // ph: 0 idle, 1 read outstanding, 2 changing channel; age: cycles spent on the read.
   int         ph  [2] = '{0, 0};
   int         age [2] = '{0, 0};
   int         cur [2] = '{0, 0};
   int         pd  [2] = '{0, 0};
   int         tgt [2] = '{0, 0};
   bit         pv  [2] = '{0, 0};
   bit         mdrdy [2] = '{0, 0};
   logic [7:0] md  [2] = '{8'h00, 8'h00};

   function automatic int next_ready(int base);
      for (int k = 1; k < NCH; k++) if (drdy_i[(base + k) % NCH]) return (base + k) % NCH;
      return -1;
   endfunction

   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (reset) begin
            ph[m] = 0; age[m] = 0; cur[m] = 0; pv[m] = 0; pd[m] = 0; tgt[m] = 0;
            md[m] = 8'h00; mdrdy[m] = 0;
         end else begin
            mdrdy[m] = 0;
            if (ph[m] == 0) begin
               if (rd) begin
                  ph[m] = 1; age[m] = 1;
               end else if (m == 0 && pv[m]) begin
                  ph[m] = 2;
               end else if (m == 1 && !drdy_i[cur[m]] && next_ready(cur[m]) >= 0) begin
                  tgt[m] = next_ready(cur[m]); ph[m] = 2;
               end
            end else if (ph[m] == 1) begin
               if (drdy_i[cur[m]]) begin
                  md[m] = d_i[cur[m] * DW +: DW]; mdrdy[m] = 1; ph[m] = 0;
               end else if (age[m] == TMO) begin
                  ph[m] = 0;
               end else begin
                  age[m]++;
               end
            end else begin
               cur[m] = (m == 0) ? pd[m] : tgt[m];
               pv[m]  = 0;
               ph[m]  = 0;
            end
            if (m == 0 && sel_wr && int'(sel_req) < NCH) begin
               pv[m] = 1; pd[m] = int'(sel_req);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b0; sel_req = 2'd0; sel_wr = 1'b0; rd = 1'b0; wr = 1'b0;
      drdy_i = '0; d_i = '0; w_sel_req = 3'd0; w_sel_wr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; rd = 1'b1; wr = 1'b1;
      @(negedge clk);
      n_cmp++; if (rd_o_m !== 4'b0) begin n_err++;
         $display("FAIL reset_rd_o got %b want 0000", rd_o_m); end
      n_cmp++; if (wr_o_m !== 4'b0) begin n_err++;
         $display("FAIL reset_wr_o got %b want 0000", wr_o_m); end
      tick();
      @(negedge clk);
      n_cmp++; if ({cur_m, busy_m, drdy_m, d_m, tmo_m} !== 13'd0) begin n_err++;
         $display("FAIL reset_state got cur=%0d busy=%b drdy=%b d=%h tmo=%b want all 0",
                  cur_m, busy_m, drdy_m, d_m, tmo_m); end
      tick();
      idle_inputs();
   endtask

   task automatic test_read();
      sel_wr = 1'b1; sel_req = 2'd2; tick();
      sel_wr = 1'b0; tick();
      wr = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy_m !== 1'b1) begin n_err++;
         $display("FAIL read_switch_busy got %b want 1", busy_m); end
      n_cmp++; if (wr_o_m !== 4'b0) begin n_err++;
         $display("FAIL read_switch_wr_block got %b want 0000", wr_o_m); end
      tick();
      rd = 1'b1; d_i = 32'h11A5_3C22;
      @(negedge clk);
      n_cmp++; if (cur_m !== 2'd2) begin n_err++;
         $display("FAIL read_cur got %0d want 2", cur_m); end
      n_cmp++; if (rd_o_m !== 4'b0100) begin n_err++;
         $display("FAIL read_rd_o got %b want 0100", rd_o_m); end
      n_cmp++; if (wr_o_m !== 4'b0100) begin n_err++;
         $display("FAIL read_wr_o got %b want 0100", wr_o_m); end
      tick();
      wr = 1'b0; drdy_i = 4'b0001;
      @(negedge clk);
      n_cmp++; if (rd_o_m !== 4'b0) begin n_err++;
         $display("FAIL read_wait_rd_o got %b want 0000", rd_o_m); end
      tick();
      rd = 1'b0; drdy_i = 4'b0100;
      @(negedge clk);
      n_cmp++; if (drdy_m !== 1'b0) begin n_err++;
         $display("FAIL read_unselected_drdy got %b want 0", drdy_m); end
      tick();
      drdy_i = '0;
      @(negedge clk);
      n_cmp++; if ({drdy_m, d_m, busy_m} !== {1'b1, 8'hA5, 1'b0}) begin n_err++;
         $display("FAIL read_data got drdy=%b d=%h busy=%b want 1 a5 0", drdy_m, d_m, busy_m);
      end
      tick();
      @(negedge clk);
      n_cmp++; if ({drdy_m, d_m} !== {1'b0, 8'hA5}) begin n_err++;
         $display("FAIL read_pulse_end got drdy=%b d=%h want 0 a5", drdy_m, d_m); end
      tick();
   endtask

   task automatic test_timeout();
      rd = 1'b1; tick();
      rd = 1'b0;
      for (int i = 1; i <= TMO; i++) begin
         @(negedge clk);
         n_cmp++; if (tmo_m !== (i == TMO)) begin n_err++;
            $display("FAIL tmo_pulse wait_cycle=%0d got %b want %b", i, tmo_m, i == TMO); end
         n_cmp++; if (busy_m !== 1'b1) begin n_err++;
            $display("FAIL tmo_busy wait_cycle=%0d got %b want 1", i, busy_m); end
         tick();
      end
      @(negedge clk);
      n_cmp++; if ({busy_m, tmo_m, drdy_m, d_m} !== {3'b000, 8'hA5}) begin n_err++;
         $display("FAIL tmo_after got busy=%b tmo=%b drdy=%b d=%h want 0 0 0 a5",
                  busy_m, tmo_m, drdy_m, d_m); end
      tick();
   endtask

   task automatic test_reset_wait();
      rd = 1'b1; tick();
      rd = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy_m !== 1'b1) begin n_err++;
         $display("FAIL rstwait_busy got %b want 1", busy_m); end
      tick();
      reset = 1'b1; drdy_i = 4'b0100; tick();
      reset = 1'b0; drdy_i = '0;
      @(negedge clk);
      n_cmp++; if ({drdy_m, d_m, busy_m, cur_m, tmo_m} !== 13'd0) begin n_err++;
         $display("FAIL rstwait_state got drdy=%b d=%h busy=%b cur=%0d tmo=%b want all 0",
                  drdy_m, d_m, busy_m, cur_m, tmo_m); end
      tick();
   endtask

   task automatic test_pending();
      sel_wr = 1'b1; sel_req = 2'd1; tick();
      sel_wr = 1'b0; tick(); tick();
      rd = 1'b1; tick();
      rd = 1'b0; sel_wr = 1'b1; sel_req = 2'd3; tick();
      sel_wr = 1'b0; tick(); tick(); tick();
      drdy_i = 4'b0010; d_i = 32'h0000_5A00; tick();
      drdy_i = '0;
      @(negedge clk);
      n_cmp++; if ({drdy_m, d_m, cur_m, busy_m} !== {1'b1, 8'h5A, 2'd1, 1'b0}) begin n_err++;
         $display("FAIL pend_data got drdy=%b d=%h cur=%0d busy=%b want 1 5a 1 0",
                  drdy_m, d_m, cur_m, busy_m); end
      tick();
      sel_wr = 1'b1; sel_req = 2'd0;
      @(negedge clk);
      n_cmp++; if ({busy_m, cur_m} !== {1'b1, 2'd1}) begin n_err++;
         $display("FAIL pend_switch got busy=%b cur=%0d want 1 1", busy_m, cur_m); end
      tick();
      sel_wr = 1'b0;
      @(negedge clk);
      n_cmp++; if ({busy_m, cur_m} !== {1'b0, 2'd3}) begin n_err++;
         $display("FAIL pend_applied got busy=%b cur=%0d want 0 3", busy_m, cur_m); end
      tick();
      @(negedge clk);
      n_cmp++; if (busy_m !== 1'b1) begin n_err++;
         $display("FAIL pend_kept_switch got busy=%b want 1", busy_m); end
      tick();
      @(negedge clk);
      n_cmp++; if ({busy_m, cur_m} !== {1'b0, 2'd0}) begin n_err++;
         $display("FAIL pend_kept_applied got busy=%b cur=%0d want 0 0", busy_m, cur_m); end
      tick();
   endtask

   task automatic test_auto();
      reset = 1'b1; tick();
      reset = 1'b0; drdy_i = 4'b1000;
      @(negedge clk);
      n_cmp++; if ({busy_a, cur_a} !== {1'b0, 2'd0}) begin n_err++;
         $display("FAIL auto_start got busy=%b cur=%0d want 0 0", busy_a, cur_a); end
      tick();
      @(negedge clk);
      n_cmp++; if (busy_a !== 1'b1) begin n_err++;
         $display("FAIL auto_switch1 got %b want 1", busy_a); end
      tick();
      drdy_i = 4'b0011;
      @(negedge clk);
      n_cmp++; if ({busy_a, cur_a} !== {1'b0, 2'd3}) begin n_err++;
         $display("FAIL auto_cur3 got busy=%b cur=%0d want 0 3", busy_a, cur_a); end
      n_cmp++; if (cur_m !== 2'd0) begin n_err++;
         $display("FAIL auto_manual_ignores got cur=%0d want 0", cur_m); end
      tick();
      drdy_i = '0;
      @(negedge clk);
      n_cmp++; if (busy_a !== 1'b1) begin n_err++;
         $display("FAIL auto_switch2 got %b want 1", busy_a); end
      tick();
      sel_wr = 1'b1; sel_req = 2'd2;
      @(negedge clk);
      n_cmp++; if ({busy_a, cur_a} !== {1'b0, 2'd0}) begin n_err++;
         $display("FAIL auto_wrap got busy=%b cur=%0d want 0 0", busy_a, cur_a); end
      tick();
      sel_wr = 1'b0; tick();
      @(negedge clk);
      n_cmp++; if ({busy_a, cur_a} !== {1'b0, 2'd0}) begin n_err++;
         $display("FAIL auto_sel_ignored got busy=%b cur=%0d want 0 0", busy_a, cur_a); end
      tick();
   endtask

   task automatic test_oob();
      w_sel_wr = 1'b1; w_sel_req = 3'd5; tick();
      w_sel_req = 3'd7; tick();
      w_sel_wr = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++; if ({w_busy, w_cur} !== {1'b0, 3'd0}) begin n_err++;
            $display("FAIL oob_dropped got busy=%b cur=%0d want 0 0", w_busy, w_cur); end
         tick();
      end
      w_sel_wr = 1'b1; w_sel_req = 3'd4; tick();
      w_sel_wr = 1'b0; tick();
      @(negedge clk);
      n_cmp++; if (w_busy !== 1'b1) begin n_err++;
         $display("FAIL oob_valid_switch got %b want 1", w_busy); end
      tick();
      @(negedge clk);
      n_cmp++; if ({w_busy, w_cur} !== {1'b0, 3'd4}) begin n_err++;
         $display("FAIL oob_valid_cur got busy=%b cur=%0d want 0 4", w_busy, w_cur); end
      tick();
   endtask

   task automatic test_random();
      logic [20:0] got, want;
      logic [3:0]  e_rd, e_wr;
      logic        e_tmo;
      for (int c = 0; c < 800; c++) begin
         reset   = ($urandom_range(99) == 0);
         rd      = ($urandom_range(3) == 0);
         wr      = ($urandom_range(2) == 0);
         sel_wr  = ($urandom_range(9) == 0);
         sel_req = 2'($urandom_range(3));
         drdy_i  = 4'($urandom) & 4'($urandom) & 4'($urandom);
         d_i     = $urandom;
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            e_rd  = (!reset && ph[m] == 0 && rd) ? 4'(1 << cur[m]) : 4'b0;
            e_wr  = (!reset && ph[m] != 2 && wr) ? 4'(1 << cur[m]) : 4'b0;
            e_tmo = !reset && ph[m] == 1 && !drdy_i[cur[m]] && age[m] == TMO;
            want  = {e_rd, e_wr, ph[m] != 0, e_tmo, 2'(cur[m]), mdrdy[m], md[m]};
            got   = (m == 0) ? {rd_o_m, wr_o_m, busy_m, tmo_m, cur_m, drdy_m, d_m}
                             : {rd_o_a, wr_o_a, busy_a, tmo_a, cur_a, drdy_a, d_a};
            n_cmp++;
            if (got !== want) begin
               n_err++;
               $display("FAIL rand inst=%0d cyc=%0d {rd_o,wr_o,busy,tmo,cur,drdy,d} got %h want %h",
                        m, c, got, want);
            end
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      reset = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_read();
      test_timeout();
      test_reset_wait();
      test_pending();
      test_auto();
      test_oob();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
